// File: rtl/scaler_job_ctrl.sv
// scaler_job_ctrl: sequences one scaling job (clear frame RAM, run engine, report done/err)
// and owns the frame-RAM write port, muxing the clear writer and the engine write port.
module scaler_job_ctrl #(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned RAM_DEPTH = 76800,
    parameter logic [7:0]  CLEAR_VAL = 8'h00,
    parameter int unsigned TIMEOUT   = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    output logic [1:0]        eng_sel,
    output logic              eng_run,
    input  logic [ADDR_W-1:0] eng_wraddr,
    input  logic [7:0]        eng_wrdata,
    input  logic              eng_wren,
    input  logic              eng_done,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned       CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q;
    logic [1:0]        eng_sel_q;
    logic [ADDR_W-1:0] clear_addr_q;
    logic [CNT_W-1:0]  run_cnt_q;
    logic              err_q;

    // Job sequencer: state, latched mode, clear address, run-cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            eng_sel_q    <= 2'b00;
            clear_addr_q <= '0;
            run_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else if (abort) begin
            // abort wins over start and eng_done; err is deliberately kept
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        eng_sel_q    <= mode;
                        err_q        <= 1'b0;
                        clear_addr_q <= '0;
                        state_q      <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clear_addr_q == CLEAR_LAST) begin
                        run_cnt_q <= '0;
                        state_q   <= RUN;
                    end else begin
                        clear_addr_q <= clear_addr_q + ADDR_W'(1);
                    end
                end
                RUN: begin
                    run_cnt_q <= run_cnt_q + CNT_W'(1);
                    // first RUN cycle is the engine's reset release, so eng_done is not trusted there
                    if ((run_cnt_q != '0) && eng_done) begin
                        state_q <= DONE;
                    end else if (run_cnt_q == RUN_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode of the registered state, including the frame-RAM write-port mux.
    always_comb begin
        eng_run    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        ram_wren   = 1'b0;
        ram_wraddr = '0;
        ram_data   = 8'h00;
        unique case (state_q)
            CLEAR: begin
                busy       = 1'b1;
                ram_wren   = 1'b1;
                ram_wraddr = clear_addr_q;
                ram_data   = CLEAR_VAL;
            end
            RUN: begin
                busy       = 1'b1;
                eng_run    = 1'b1;
                ram_wren   = eng_wren;
                ram_wraddr = eng_wraddr;
                ram_data   = eng_wrdata;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign eng_sel = eng_sel_q;
    assign err     = err_q;

endmodule

// File: tb/tb_scaler_job_ctrl.sv
// Directed bench for scaler_job_ctrl with RAM_DEPTH=16, TIMEOUT=64.
module tb_scaler_job_ctrl;

    localparam int unsigned ADDR_W = 19;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [1:0]        eng_sel;
    logic              eng_run;
    logic [ADDR_W-1:0] eng_wraddr;
    logic [7:0]        eng_wrdata;
    logic              eng_wren;
    logic              eng_done;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [7:0]        ram_data;
    logic              ram_wren;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int passes = 0;

    scaler_job_ctrl #(
        .ADDR_W   (ADDR_W),
        .RAM_DEPTH(16),
        .CLEAR_VAL(8'h00),
        .TIMEOUT  (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .eng_sel   (eng_sel),
        .eng_run   (eng_run),
        .eng_wraddr(eng_wraddr),
        .eng_wrdata(eng_wrdata),
        .eng_wren  (eng_wren),
        .eng_done  (eng_done),
        .ram_wraddr(ram_wraddr),
        .ram_data  (ram_data),
        .ram_wren  (ram_wren),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one-cycle start pulse with the given mode; returns in the first CLEAR cycle
    task automatic pulse_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        eng_wren = 1'b1;
        eng_wraddr = 19'h7FFFF;
        eng_wrdata = 8'hFF;
        repeat (3) tick();
        checks++; if ({eng_run, busy, done, ram_wren, err} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {eng_run, busy, done, ram_wren, err}); else passes++;
        checks++; if ({ram_wraddr, ram_data, eng_sel} !== 29'h0) $display("FAIL reset_bus: got addr=%h data=%h sel=%b want 0", ram_wraddr, ram_data, eng_sel); else passes++;
        reset = 1'b1;
        repeat (10) tick();
        checks++; if ({busy, done, ram_wren, eng_run} !== 4'b0) $display("FAIL idle_hold: got %b want 0000", {busy, done, ram_wren, eng_run}); else passes++;
        checks++; if (ram_wraddr !== 19'h0) $display("FAIL idle_addr_block: got %h want 0", ram_wraddr); else passes++;
    endtask

    task automatic test_normal_job();
        pulse_start(2'b01);
        mode = 2'b10;
        checks++; if (eng_sel !== 2'b01) $display("FAIL job_eng_sel: got %b want 01", eng_sel); else passes++;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({eng_run, busy, ram_wren, ram_wraddr, ram_data} !== {1'b0, 1'b1, 1'b1, 19'(i), 8'h00})
                $display("FAIL clear_write_%0d: got run=%b busy=%b wren=%b addr=%h data=%h want 0 1 1 %h 00",
                         i, eng_run, busy, ram_wren, ram_wraddr, ram_data, 19'(i));
            else passes++;
            tick();
        end
        checks++; if ({eng_run, busy} !== 2'b11) $display("FAIL run_entry: got %b want 11", {eng_run, busy}); else passes++;
        eng_wraddr = 19'h12345;
        eng_wrdata = 8'hA5;
        eng_wren = 1'b1;
        #1;
        checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 19'h12345, 8'hA5}) $display("FAIL passthrough: got %b %h %h want 1 12345 a5", ram_wren, ram_wraddr, ram_data); else passes++;
        eng_wren = 1'b0;
        #1;
        checks++; if (ram_wren !== 1'b0) $display("FAIL passthrough_wren0: got %b want 0", ram_wren); else passes++;
        eng_wren = 1'b1;
        repeat (19) tick();
        checks++; if ({busy, done} !== 2'b10) $display("FAIL run_cycle20: got %b want 10", {busy, done}); else passes++;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        checks++; if ({done, err, busy, eng_run, ram_wren} !== 5'b10000) $display("FAIL job_done: got %b want 10000", {done, err, busy, eng_run, ram_wren}); else passes++;
        checks++; if ({ram_wraddr, ram_data} !== 27'h0) $display("FAIL done_bus_block: got %h %h want 0 0", ram_wraddr, ram_data); else passes++;
        eng_wren = 1'b0;
    endtask

    task automatic test_timeout();
        pulse_start(2'b10);
        checks++; if (eng_sel !== 2'b10) $display("FAIL to_eng_sel: got %b want 10", eng_sel); else passes++;
        repeat (16) tick();
        repeat (63) tick();
        checks++; if ({busy, done, err} !== 3'b100) $display("FAIL to_last_run: got %b want 100", {busy, done, err}); else passes++;
        tick();
        checks++; if ({done, err, eng_run, busy} !== 4'b1100) $display("FAIL to_expired: got %b want 1100", {done, err, eng_run, busy}); else passes++;
        pulse_start(2'b00);
        checks++; if ({err, busy, ram_wren} !== 3'b011) $display("FAIL to_err_clear: got %b want 011", {err, busy, ram_wren}); else passes++;
    endtask

    task automatic test_abort();
        repeat (7) tick();
        checks++; if (ram_wraddr !== 19'd7) $display("FAIL abort_pre_addr: got %h want 7", ram_wraddr); else passes++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if ({ram_wren, busy, eng_run, done} !== 4'b0) $display("FAIL abort_clear: got %b want 0000", {ram_wren, busy, eng_run, done}); else passes++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL abort_stays_idle: got %b want 0", busy); else passes++;
        pulse_start(2'b00);
        repeat (16) tick();
        repeat (4) tick();
        eng_done = 1'b1;
        abort = 1'b1;
        tick();
        eng_done = 1'b0;
        abort = 1'b0;
        checks++; if ({done, busy, eng_run} !== 3'b000) $display("FAIL abort_run: got %b want 000", {done, busy, eng_run}); else passes++;
        tick();
        checks++; if (done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", done); else passes++;
    endtask

    task automatic test_ignore_start();
        pulse_start(2'b01);
        repeat (3) tick();
        pulse_start(2'b11);
        checks++; if ({eng_sel, ram_wraddr} !== {2'b01, 19'd4}) $display("FAIL ign_clear: got sel=%b addr=%h want 01 4", eng_sel, ram_wraddr); else passes++;
        repeat (12) tick();
        checks++; if (eng_run !== 1'b1) $display("FAIL ign_run_entry: got %b want 1", eng_run); else passes++;
        pulse_start(2'b11);
        checks++; if ({eng_sel, eng_run, busy} !== 4'b0111) $display("FAIL ign_run: got %b want 0111", {eng_sel, eng_run, busy}); else passes++;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        checks++; if (done !== 1'b1) $display("FAIL ign_done: got %b want 1", done); else passes++;
        pulse_start(2'b11);
        checks++; if ({eng_sel, ram_wren, ram_wraddr, busy, done} !== {2'b11, 1'b1, 19'd0, 1'b1, 1'b0}) $display("FAIL restart_from_done: got sel=%b wren=%b addr=%h busy=%b done=%b", eng_sel, ram_wren, ram_wraddr, busy, done); else passes++;
    endtask

    task automatic test_stale_done_and_reset();
        repeat (16) tick();
        eng_done = 1'b1;
        tick();
        checks++; if ({busy, done} !== 2'b10) $display("FAIL stale_done: got %b want 10", {busy, done}); else passes++;
        tick();
        eng_done = 1'b0;
        checks++; if (done !== 1'b1) $display("FAIL second_cycle_done: got %b want 1", done); else passes++;
        pulse_start(2'b10);
        repeat (16) tick();
        repeat (3) tick();
        checks++; if (eng_run !== 1'b1) $display("FAIL pre_reset_run: got %b want 1", eng_run); else passes++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if ({busy, eng_run, done, eng_sel, ram_wren} !== 6'b0) $display("FAIL reset_mid_run: got %b want 000000", {busy, eng_run, done, eng_sel, ram_wren}); else passes++;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode = 2'b00;
        eng_wraddr = '0;
        eng_wrdata = 8'h00;
        eng_wren = 1'b0;
        eng_done = 1'b0;
        test_reset();
        test_normal_job();
        test_timeout();
        test_abort();
        test_ignore_start();
        test_stale_done_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
